fetch_queue: RTL and testbench

Instruction fetch front end for the pipelined RISC-V core. It generates fetch addresses, issues one-at-a-time requests to a variable-latency instruction memory, and buffers the returned instructions with their PCs in a small FIFO. The IF/ID register consumes the FIFO head. A taken branch from the MEM stage redirects the queue by flushing buffered and in-flight instructions and restarting fetch at the target PC.

---
 rtl/fetch_queue.sv | 168 ++++++++++++++++
 tb/tb_fetch_queue.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end with a {instr, pc} FIFO.
// Issues one outstanding imem request at a time; a redirect flushes and refetches.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   redirect            taken branch from MEM, restarts fetch at redirect_pc
//   redirect_pc [63:0]  branch target
//   deq                 consumer takes the FIFO head (ignored when empty)
//   imem_req            request valid (registered)
//   imem_addr [63:0]    request address, stable while imem_req is high
//   imem_ack            response valid, may arrive in the first req cycle
//   imem_rdata [31:0]   returned instruction
//   instr_valid         FIFO non-empty
//   instr_out [31:0]    head instruction, NOP when empty
//   pc_out [63:0]       head PC, zero when empty
//   count               entries held
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [63:0]                redirect_pc,
    input  logic                       deq,
    output logic                       imem_req,
    output logic [63:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    output logic                       instr_valid,
    output logic [31:0]                instr_out,
    output logic [63:0]                pc_out,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0]   NOP  = 32'h0000_0013;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    r_state;
    logic          r_req;
    logic [63:0]   r_fetch_pc;
    logic [63:0]   r_pend_pc;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_instr [DEPTH];
    logic [63:0]   r_pc    [DEPTH];

    logic          w_busy;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [CW-1:0] w_count_nxt;
    logic [1:0]    w_state_nxt;
    logic [63:0]   w_fetch_nxt;
    logic [63:0]   w_pend_nxt;
    logic [63:0]   w_pend_sel;

    assign w_busy  = (r_state == S_BUSY);
    assign w_empty = (r_count == '0);

    // A redirect overrides both a same-cycle push and a same-cycle pop.
    assign w_push = w_busy & imem_ack & ~redirect;
    assign w_pop  = deq & ~w_empty & ~redirect;

    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // In DRAIN the most recent redirect target wins, even on the ack cycle.
    assign w_pend_sel = redirect ? redirect_pc : r_pend_pc;

    always_comb begin
        w_state_nxt = r_state;
        w_fetch_nxt = r_fetch_pc;
        w_pend_nxt  = r_pend_pc;
        unique case (r_state)
            S_IDLE: begin
                if (redirect) begin
                    w_fetch_nxt = redirect_pc;
                    w_state_nxt = S_BUSY;
                end else if (r_count < FULL) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (imem_ack) begin
                    if (redirect) begin
                        w_fetch_nxt = redirect_pc;
                    end else begin
                        w_fetch_nxt = r_fetch_pc + 64'd4;
                        if (w_count_nxt >= FULL) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end else if (redirect) begin
                    // Old request still in flight: keep its address on the
                    // bus and remember where to go once it returns.
                    w_pend_nxt  = redirect_pc;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_pend_nxt = w_pend_sel;
                if (imem_ack) begin
                    w_fetch_nxt = w_pend_sel;
                    w_state_nxt = S_BUSY;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= (w_state_nxt != S_IDLE);
            r_fetch_pc <= w_fetch_nxt;
            r_pend_pc  <= w_pend_nxt;
            if (redirect) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + PW'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + PW'(1);
                end
                r_count <= w_count_nxt;
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_instr[r_tail] <= imem_rdata;
            r_pc[r_tail]    <= r_fetch_pc;
        end
    end

    // imem_addr is the fetch PC register; it is left untouched in DRAIN so
    // the outstanding request keeps its original address.
    assign imem_req    = r_req;
    assign imem_addr   = r_fetch_pc;
    assign instr_valid = ~w_empty;
    assign instr_out   = w_empty ? NOP : r_instr[r_head];
    assign pc_out      = w_empty ? 64'd0 : r_pc[r_head];
    assign count       = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table plus hand sequences for fetch_queue.
// Inputs are driven #1 after each rising edge; outputs checked #1 after the next.
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        deq;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [63:0] pc_out;
    logic [2:0]  count;

    int n_chk = 0;
    int n_bad = 0;

    fetch_queue #(.DEPTH(4), .RESET_PC(64'd0)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .deq         (deq),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdr;
        logic [63:0] rpc;
        logic        dq;
        logic        ack;
        logic [31:0] rd;
        logic        req;
        logic [63:0] addr;
        logic        vld;
        logic [31:0] ins;
        logic [63:0] pc;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tv[$];

    function automatic logic [31:0] iw(input logic [63:0] a);
        return 32'h1000_0000 + a[31:0];
    endfunction

    function automatic void add(
        input logic rst, input logic rdr, input logic [63:0] rpc,
        input logic dq, input logic ack, input logic [31:0] rd,
        input logic req, input logic [63:0] addr, input logic vld,
        input logic [31:0] ins, input logic [63:0] pc, input logic [2:0] cnt);
        vec_t v;
        v.rst = rst; v.rdr = rdr; v.rpc = rpc; v.dq = dq;
        v.ack = ack; v.rd = rd; v.req = req; v.addr = addr;
        v.vld = vld; v.ins = ins; v.pc = pc; v.cnt = cnt;
        tv.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic rdr, input logic [63:0] rpc,
                         input logic dq, input logic ack, input logic [31:0] rd);
        reset = rst; redirect = rdr; redirect_pc = rpc;
        deq = dq; imem_ack = ack; imem_rdata = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
        deq = 1'b0; imem_ack = 1'b0; imem_rdata = '0;

        //  rst rdr rpc      dq ack rd            req addr     vld ins           pc      cnt
        add(1, 0, 64'h0,   0, 0, 32'h0,        0, 64'h0,   0, NOP,          64'h0,   0);
        add(0, 0, 64'h0,   0, 0, 32'h0,        1, 64'h0,   0, NOP,          64'h0,   0);
        add(0, 0, 64'h0,   1, 1, iw(0),        1, 64'h4,   1, iw(0),        64'h0,   1);
        add(0, 0, 64'h0,   1, 1, iw(4),        1, 64'h8,   1, iw(4),        64'h4,   1);
        add(0, 0, 64'h0,   1, 1, iw(8),        1, 64'hC,   1, iw(8),        64'h8,   1);
        add(0, 0, 64'h0,   0, 1, iw(12),       1, 64'h10,  1, iw(8),        64'h8,   2);
        add(0, 0, 64'h0,   0, 1, iw(16),       1, 64'h14,  1, iw(8),        64'h8,   3);
        add(0, 0, 64'h0,   0, 1, iw(20),       0, 64'h18,  1, iw(8),        64'h8,   4);
        add(0, 0, 64'h0,   0, 1, 32'hDEADBEEF, 0, 64'h18,  1, iw(8),        64'h8,   4);
        add(0, 0, 64'h0,   1, 0, 32'h0,        0, 64'h18,  1, iw(12),       64'hC,   3);
        add(0, 0, 64'h0,   0, 0, 32'h0,        1, 64'h18,  1, iw(12),       64'hC,   3);
        add(0, 0, 64'h0,   0, 0, 32'h0,        1, 64'h18,  1, iw(12),       64'hC,   3);
        add(0, 0, 64'h0,   0, 0, 32'h0,        1, 64'h18,  1, iw(12),       64'hC,   3);
        add(0, 0, 64'h0,   0, 1, iw(24),       0, 64'h1C,  1, iw(12),       64'hC,   4);
        add(0, 0, 64'h0,   1, 0, 32'h0,        0, 64'h1C,  1, iw(16),       64'h10,  3);
        add(0, 0, 64'h0,   1, 0, 32'h0,        1, 64'h1C,  1, iw(20),       64'h14,  2);
        add(0, 0, 64'h0,   1, 0, 32'h0,        1, 64'h1C,  1, iw(24),       64'h18,  1);
        add(0, 0, 64'h0,   1, 0, 32'h0,        1, 64'h1C,  0, NOP,          64'h0,   0);
        add(0, 0, 64'h0,   0, 1, iw(28),       1, 64'h20,  1, iw(28),       64'h1C,  1);
        add(0, 1, 64'h180, 0, 0, 32'h0,        1, 64'h20,  0, NOP,          64'h0,   0);
        add(0, 0, 64'h0,   0, 0, 32'h0,        1, 64'h20,  0, NOP,          64'h0,   0);
        add(0, 1, 64'h100, 0, 0, 32'h0,        1, 64'h20,  0, NOP,          64'h0,   0);
        add(0, 0, 64'h0,   0, 1, 32'hDEADBEEF, 1, 64'h100, 0, NOP,          64'h0,   0);
        add(0, 0, 64'h0,   0, 1, iw(64'h100),  1, 64'h104, 1, iw(64'h100),  64'h100, 1);
        add(0, 1, 64'h200, 1, 1, iw(64'h104),  1, 64'h200, 0, NOP,          64'h0,   0);
        add(0, 0, 64'h0,   0, 1, iw(64'h200),  1, 64'h204, 1, iw(64'h200),  64'h200, 1);
        add(0, 0, 64'h0,   0, 1, iw(64'h204),  1, 64'h208, 1, iw(64'h200),  64'h200, 2);
        add(0, 0, 64'h0,   0, 1, iw(64'h208),  1, 64'h20C, 1, iw(64'h200),  64'h200, 3);
        add(1, 0, 64'h0,   0, 1, iw(64'h20C),  0, 64'h0,   0, NOP,          64'h0,   0);
        add(0, 0, 64'h0,   0, 0, 32'h0,        1, 64'h0,   0, NOP,          64'h0,   0);
        add(0, 0, 64'h0,   0, 1, iw(0),        1, 64'h4,   1, iw(0),        64'h0,   1);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].rdr, tv[i].rpc, tv[i].dq, tv[i].ack, tv[i].rd);
            chk($sformatf("v%0d req", i),   64'(imem_req),    64'(tv[i].req));
            chk($sformatf("v%0d addr", i),  imem_addr,        tv[i].addr);
            chk($sformatf("v%0d valid", i), 64'(instr_valid), 64'(tv[i].vld));
            chk($sformatf("v%0d instr", i), 64'(instr_out),   64'(tv[i].ins));
            chk($sformatf("v%0d pc", i),    pc_out,           tv[i].pc);
            chk($sformatf("v%0d count", i), 64'(count),       64'(tv[i].cnt));
        end

        // Fill to DEPTH with zero-wait memory, then stall in IDLE.
        for (int k = 1; k <= 3; k++) begin
            drive(0, 0, 64'h0, 0, 1, iw(64'(4 * k)));
            chk($sformatf("fill%0d count", k), 64'(count), 64'(k + 1));
            chk($sformatf("fill%0d req", k), 64'(imem_req), 64'(k < 3));
            chk($sformatf("fill%0d addr", k), imem_addr, 64'(4 * k + 4));
        end
        chk("full head pc", pc_out, 64'h0);

        // Redirect from IDLE with a same-cycle deq: request goes out at once.
        drive(0, 1, 64'h400, 1, 0, 32'h0);
        chk("idle_rdr req", 64'(imem_req), 64'd1);
        chk("idle_rdr addr", imem_addr, 64'h400);
        chk("idle_rdr count", 64'(count), 64'd0);
        chk("idle_rdr valid", 64'(instr_valid), 64'd0);

        // Three-cycle memory latency with the consumer always ready.
        for (int k = 0; k < 2; k++) begin
            logic [63:0] a;
            a = 64'h400 + 64'(4 * k);
            for (int w = 0; w < 3; w++) begin
                drive(0, 0, 64'h0, 1, (w == 2), (w == 2) ? iw(a) : 32'h0);
                if (w < 2) begin
                    chk($sformatf("lat%0d.%0d req", k, w), 64'(imem_req), 64'd1);
                    chk($sformatf("lat%0d.%0d addr", k, w), imem_addr, a);
                    chk($sformatf("lat%0d.%0d valid", k, w),
                        64'(instr_valid), 64'd0);
                    chk($sformatf("lat%0d.%0d nop", k, w), 64'(instr_out), 64'(NOP));
                end else begin
                    chk($sformatf("lat%0d valid", k), 64'(instr_valid), 64'd1);
                    chk($sformatf("lat%0d pc", k), pc_out, a);
                    chk($sformatf("lat%0d instr", k), 64'(instr_out), 64'(iw(a)));
                    chk($sformatf("lat%0d next", k), imem_addr, a + 64'd4);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
